mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
//  Initiator side of the word-wide data SRAM interface (14-bit word addr, we, wd, rd).
//  Sits in the MEM stage and turns lw/lh/lhu/lb/lbu/sw/sh/sb requests into SRAM word
//  accesses, doing read-modify-write for sub-word stores. Stalls the pipeline via busy.
//  Flags misaligned accesses; it never touches SRAM for them.
// PARAMETERS
//  ADDR_W  14  SRAM word-address width; mem_addr = addr_q[ADDR_W+1:2], upper bits ignored
// PORTS
//  clk       in   1       single clock; all state updates on posedge
//  reset     in   1       asynchronous, active-low reset (0 = reset)
//  req       in   1       access request; sampled only in IDLE
//  we_req    in   1       1 = store, 0 = load
//  size      in   2       0 byte, 1 half, 2 word, 3 illegal
//  sign_ext  in   1       loads only: 1 sign-extend, 0 zero-extend
//  addr      in   32      byte address
//  wdata     in   32      store data, right-justified (byte in [7:0], half in [15:0])
//  busy      out  1       stall: high from accepting cycle until the cycle before done
//  done      out  1       one-cycle pulse, access complete; rdata valid this cycle
//  rdata     out  32      extended load result; held until the next load completes
//  misalign  out  1       one-cycle pulse: request rejected
//  mem_addr  out  ADDR_W  SRAM word address
//  mem_we    out  1       SRAM write enable (SRAM writes on posedge)
//  mem_wd    out  32      SRAM write data
//  mem_rd    in   32      SRAM combinational read data
// BEHAVIOUR
//  - Reset (reset=0, async): state IDLE; busy, done, misalign, mem_we = 0;
//    rdata, mem_addr, mem_wd = 0. A reset mid-operation aborts it with no SRAM write.
//  - Byte lanes are little-endian: lane k = word[8k+7:8k], k = addr[1:0]; half lane = addr[1].
//  - Misaligned: size==3, half with addr[0]=1, or word with addr[1:0]!=0. In IDLE this gives
//    misalign=1 combinationally for that cycle only. busy=0, mem_we=0, the FSM stays IDLE.
//  - Accept: in IDLE with req=1 and aligned, latch we_req/size/sign_ext/addr/wdata.
//    busy=1 combinationally in that same cycle.
//  - FSM states: IDLE, ACCESS, READ, WRITE, DONE.
//    IDLE -acc-> ACCESS (load or sw) | READ (sb/sh).
//    ACCESS -> DONE: a load captures extracted mem_rd into rdata; sw drives mem_we=1,
//    mem_wd=wdata_q.
//    READ -> WRITE: capture mem_rd into merge_q; mem_we=0.
//    WRITE -> DONE: mem_we=1, mem_wd = merge_q with the addressed lane(s) replaced by wdata_q.
//    DONE -> IDLE: done=1, busy=0. req in DONE is ignored.
//  - Latency from accept edge: load/sw: done in cycle 2. sb/sh: done in cycle 3.
//    Cycle 0 is the accept cycle.
//  - busy = (state in ACCESS,READ,WRITE) | (IDLE & req & aligned).
//  - mem_addr is registered from addr at accept. It holds its value in IDLE/DONE.
//  - mem_we is high in at most one cycle per store and never for loads.
//  - Load result: lb/lbu from lane k; lh/lhu from half lane. Bits above are filled with the
//    sign bit when sign_ext=1, else 0. sign_ext is ignored for lw and for stores.
//  - Inputs other than req/reset are don't-care outside the accept cycle.
// STRUCTURE
//  - mem_pkg: typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} mem_size_t.
//    mem_pkg also holds the WORD_BYTES=4 constant.
//  - FSM state enum is local to this module.
//  - Sub-module byte_lane_merge (combinational): extract+extend for loads, lane insert for
//    stores. Shared with future I/O bridge.
// TESTING (SRAM model preloaded: word 0x4 = 32'hdeadbeaf; byte addr 0x10)
//  1 lw 0x10 -> busy cyc0-1, done cyc2, rdata=32'hdeadbeaf, mem_we never high.
//  2 lb 0x11 sign_ext=1 -> 32'hffffffbe.
//    lbu 0x11 -> 32'h000000be.
//    lh 0x12 sign_ext=1 -> 32'hffffdead.
//  3 sb 0x12 wdata=32'h00000055 -> mem_we exactly in cyc2, done cyc3, word 0x4=32'hde55beaf.
//  4 sh 0x11 and size=3 at 0x10 -> misalign pulse 1 cycle, busy=0, no mem_we, word unchanged.
//  5 sb 0x10 with reset=0 asserted during READ -> mem_we stays 0, word unchanged.
//    After reset: IDLE, outputs at reset values.
//  6 sw 0x14 32'h12345678 then lw 0x14 back-to-back -> rdata=32'h12345678; lw accepted cyc3.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory access path: access sizes and word geometry.
package mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } mem_size_t;

    localparam int WORD_BYTES = 4;
    localparam int LANE_W     = $clog2(WORD_BYTES);

    // Size 3 is never aligned; halves need an even address, words a multiple of four.
    function automatic logic is_aligned(input logic [1:0] size, input logic [LANE_W-1:0] lane);
        logic ok;
        if (size == SZ_BYTE) begin
            ok = 1'b1;
        end else if (size == SZ_HALF) begin
            ok = ~lane[0];
        end else if (size == SZ_WORD) begin
            ok = (lane == 2'd0);
        end else begin
            ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/byte_lane_merge.sv
// Combinational lane logic: extracts and extends a load from a word, and inserts
// right-justified store data into the addressed lane(s) of an existing word.
module byte_lane_merge
    import mem_pkg::*;
(
    input  logic [31:0] word_in,
    input  logic [31:0] wdata,
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic [31:0] load_val,
    output logic [31:0] store_word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane selection, extension and insertion
    always_comb begin
        byte_sel   = 8'h00;
        half_sel   = lane[1] ? word_in[31:16] : word_in[15:0];
        load_val   = word_in;
        store_word = word_in;

        case (lane)
            2'd0:    byte_sel = word_in[7:0];
            2'd1:    byte_sel = word_in[15:8];
            2'd2:    byte_sel = word_in[23:16];
            2'd3:    byte_sel = word_in[31:24];
            default: byte_sel = 8'h00;
        endcase

        case (size)
            SZ_BYTE: begin
                load_val = {{24{sign_ext & byte_sel[7]}}, byte_sel};
                case (lane)
                    2'd0:    store_word[7:0]   = wdata[7:0];
                    2'd1:    store_word[15:8]  = wdata[7:0];
                    2'd2:    store_word[23:16] = wdata[7:0];
                    2'd3:    store_word[31:24] = wdata[7:0];
                    default: store_word        = word_in;
                endcase
            end
            SZ_HALF: begin
                load_val = {{16{sign_ext & half_sel[15]}}, half_sel};
                if (lane[1]) begin
                    store_word[31:16] = wdata[15:0];
                end else begin
                    store_word[15:0] = wdata[15:0];
                end
            end
            default: begin
                load_val   = word_in;
                store_word = wdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage initiator for the word-wide data SRAM: loads, word stores and
// read-modify-write sub-word stores, with pipeline stall and misalignment reporting.
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we_req,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic [31:0]       rdata,
    output logic              misalign,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [31:0]       mem_wd,
    input  logic [31:0]       mem_rd
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACCESS = 3'd1,
        ST_READ   = 3'd2,
        ST_WRITE  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic        we_q;
    logic [1:0]  size_q;
    logic        sign_ext_q;
    logic [1:0]  lane_q;
    logic [31:0] wdata_q;
    logic        aligned;
    logic        accept;
    logic [31:0] load_val;
    logic [31:0] store_word;
    logic        unused_addr_bits;

    assign aligned          = is_aligned(size, addr[1:0]);
    assign accept           = (state_q == ST_IDLE) & req & aligned;
    assign unused_addr_bits = ^addr[31:ADDR_W+2];

    byte_lane_merge u_merge (
        .word_in    (mem_rd),
        .wdata      (wdata_q),
        .lane       (lane_q),
        .size       (size_q),
        .sign_ext   (sign_ext_q),
        .load_val   (load_val),
        .store_word (store_word)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and stall/strobe decoding
    always_comb begin
        state_d  = state_q;
        busy     = 1'b0;
        done     = 1'b0;
        misalign = 1'b0;
        mem_we   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req && aligned) begin
                    busy    = 1'b1;
                    state_d = (we_req && (size != SZ_WORD)) ? ST_READ : ST_ACCESS;
                end else if (req) begin
                    misalign = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                busy    = 1'b1;
                mem_we  = we_q;
                state_d = ST_DONE;
            end
            ST_READ: begin
                busy    = 1'b1;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                busy    = 1'b1;
                mem_we  = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Request capture, SRAM address/data and load result registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            we_q       <= 1'b0;
            size_q     <= 2'd0;
            sign_ext_q <= 1'b0;
            lane_q     <= 2'd0;
            wdata_q    <= 32'h0000_0000;
            mem_addr   <= '0;
            mem_wd     <= 32'h0000_0000;
            rdata      <= 32'h0000_0000;
        end else begin
            if (accept) begin
                we_q       <= we_req;
                size_q     <= size;
                sign_ext_q <= sign_ext;
                lane_q     <= addr[1:0];
                wdata_q    <= wdata;
                mem_addr   <= addr[ADDR_W+1:2];
                // A word store drives its data straight out in ACCESS
                if (we_req && (size == SZ_WORD)) begin
                    mem_wd <= wdata;
                end
            end
            if ((state_q == ST_ACCESS) && !we_q) begin
                rdata <= load_val;
            end
            // Merge the old word with the new lane(s) so WRITE sees the final word
            if (state_q == ST_READ) begin
                mem_wd <= store_word;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized self-checking bench for mem_access_ctrl against a word-array reference model.
module tb_mem_access_ctrl;

    logic        clk;
    logic        reset;
    logic        req;
    logic        we_req;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic        misalign;
    logic [13:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    logic [31:0] sram [0:16383];
    logic        ld_en;
    logic [13:0] ld_a;
    logic [31:0] ld_d;

    logic [31:0] ref_mem [0:15];
    logic [31:0] exp_rdata;
    int          n_checks;
    int          n_fail;

    mem_access_ctrl #(.ADDR_W(14)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .we_req   (we_req),
        .size     (size),
        .sign_ext (sign_ext),
        .addr     (addr),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .rdata    (rdata),
        .misalign (misalign),
        .mem_addr (mem_addr),
        .mem_we   (mem_we),
        .mem_wd   (mem_wd),
        .mem_rd   (mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rd = sram[mem_addr];

    always @(posedge clk) begin
        if (ld_en) begin
            sram[ld_a] <= ld_d;
        end else if (mem_we) begin
            sram[mem_addr] <= mem_wd;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [31:0] a,
                                             input logic [1:0] sz, input logic sx);
        logic [31:0] v;
        int sh;
        if (sz == 2'd0) begin
            sh = 8 * int'(a[1:0]);
            v  = (w >> sh) & 32'h0000_00ff;
            if (sx && v[7]) v = v | 32'hffff_ff00;
        end else if (sz == 2'd1) begin
            sh = 16 * int'(a[1]);
            v  = (w >> sh) & 32'h0000_ffff;
            if (sx && v[15]) v = v | 32'hffff_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [31:0] a,
                                              input logic [1:0] sz, input logic [31:0] d);
        logic [31:0] mask;
        int sh;
        if (sz == 2'd0) begin
            sh   = 8 * int'(a[1:0]);
            mask = 32'h0000_00ff << sh;
        end else if (sz == 2'd1) begin
            sh   = 16 * int'(a[1]);
            mask = 32'h0000_ffff << sh;
        end else begin
            sh   = 0;
            mask = 32'hffff_ffff;
        end
        return (w & ~mask) | ((d << sh) & mask);
    endfunction

    task automatic preload(input int idx, input logic [31:0] d);
        @(negedge clk);
        ld_en = 1'b1;
        ld_a  = 14'(idx);
        ld_d  = d;
        @(negedge clk);
        ld_en = 1'b0;
        ref_mem[idx] = d;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_done"}, 32'(done), 32'd0);
        check_eq({tag, "_mis"}, 32'(misalign), 32'd0);
        check_eq({tag, "_we"}, 32'(mem_we), 32'd0);
        check_eq({tag, "_rdata"}, rdata, 32'd0);
        check_eq({tag, "_maddr"}, 32'(mem_addr), 32'd0);
        check_eq({tag, "_mwd"}, mem_wd, 32'd0);
    endtask

    // One access; returns with the bench positioned in the DONE cycle (or IDLE after a reject)
    task automatic run_op(input string tag, input logic we, input logic [1:0] sz,
                          input logic sx, input logic [31:0] a, input logic [31:0] wd);
        logic is_mis;
        int   cyc, we_cnt, we_cyc, exp_lat, idx;
        is_mis = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
        idx    = int'(a[5:2]);
        req = 1'b1; we_req = we; size = sz; sign_ext = sx; addr = a; wdata = wd;
        #1;
        if (done) begin
            @(posedge clk); #1;
        end
        check_eq({tag, "_mis0"}, 32'(misalign), 32'(is_mis));
        check_eq({tag, "_busy0"}, 32'(busy), 32'(!is_mis));
        @(posedge clk); #1;
        req = 1'b0; we_req = $urandom_range(0, 1); size = 2'($urandom_range(0, 3));
        sign_ext = $urandom_range(0, 1); addr = $urandom; wdata = $urandom;
        #1;
        if (is_mis) begin
            check_eq({tag, "_rej_busy"}, 32'(busy), 32'd0);
            check_eq({tag, "_rej_mis"}, 32'(misalign), 32'd0);
            check_eq({tag, "_rej_we"}, 32'(mem_we), 32'd0);
            check_eq({tag, "_rej_word"}, sram[idx], ref_mem[idx]);
            check_eq({tag, "_rej_rdata"}, rdata, exp_rdata);
            return;
        end
        exp_lat = (we && sz != 2'd2) ? 3 : 2;
        cyc = 1; we_cnt = 0; we_cyc = -1;
        while (cyc <= 8) begin
            if (mem_we) begin
                we_cnt++;
                we_cyc = cyc;
            end
            if (done) break;
            check_eq({tag, "_busy"}, 32'(busy), 32'd1);
            @(posedge clk); #1;
            cyc++;
        end
        check_eq({tag, "_done_seen"}, 32'(done), 32'd1);
        check_eq({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
        check_eq({tag, "_busy_done"}, 32'(busy), 32'd0);
        check_eq({tag, "_we_count"}, 32'(we_cnt), we ? 32'd1 : 32'd0);
        if (we) begin
            check_eq({tag, "_we_cycle"}, 32'(we_cyc), 32'(exp_lat - 1));
            ref_mem[idx] = ref_store(ref_mem[idx], a, sz, wd);
        end else begin
            exp_rdata = ref_load(ref_mem[idx], a, sz, sx);
        end
        check_eq({tag, "_rdata"}, rdata, exp_rdata);
        check_eq({tag, "_word"}, sram[idx], ref_mem[idx]);
    endtask

    initial begin
        n_checks = 0; n_fail = 0; exp_rdata = 32'd0;
        reset = 1'b0; req = 1'b0; we_req = 1'b0; size = 2'd0; sign_ext = 1'b0;
        addr = 32'd0; wdata = 32'd0; ld_en = 1'b0; ld_a = 14'd0; ld_d = 32'd0;
        for (int i = 0; i < 16; i++) begin
            preload(i, (i == 4) ? 32'hdeadbeaf : $urandom);
        end
        #1;
        check_reset_outputs("rst");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        run_op("lw10", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        check_eq("lw10_val", rdata, 32'hdeadbeaf);
        run_op("lb11", 1'b0, 2'd0, 1'b1, 32'h11, 32'h0);
        check_eq("lb11_val", rdata, 32'hffffffbe);
        run_op("lbu11", 1'b0, 2'd0, 1'b0, 32'h11, 32'h0);
        check_eq("lbu11_val", rdata, 32'h000000be);
        run_op("lh12", 1'b0, 2'd1, 1'b1, 32'h12, 32'h0);
        check_eq("lh12_val", rdata, 32'hffffdead);
        run_op("sb12", 1'b1, 2'd0, 1'b0, 32'h12, 32'h00000055);
        check_eq("sb12_word", sram[4], 32'hde55beaf);
        run_op("sh11", 1'b1, 2'd1, 1'b0, 32'h11, 32'h0000aaaa);
        run_op("sz3", 1'b0, 2'd3, 1'b0, 32'h10, 32'h0);
        check_eq("mis_word", sram[4], 32'hde55beaf);

        // Reset during the READ phase of a byte store
        @(negedge clk);
        req = 1'b1; we_req = 1'b1; size = 2'd0; sign_ext = 1'b0; addr = 32'h10; wdata = 32'h77;
        @(posedge clk); #1;
        req = 1'b0;
        reset = 1'b0;
        exp_rdata = 32'd0;
        #1;
        check_reset_outputs("mid_rst");
        @(posedge clk); #1;
        check_eq("mid_rst_we", 32'(mem_we), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_eq("mid_rst_word", sram[4], 32'hde55beaf);
        check_eq("mid_rst_busy", 32'(busy), 32'd0);

        run_op("sw14", 1'b1, 2'd2, 1'b0, 32'h14, 32'h12345678);
        run_op("lw14", 1'b0, 2'd2, 1'b0, 32'h14, 32'h0);
        check_eq("lw14_val", rdata, 32'h12345678);

        for (int i = 0; i < 80; i++) begin
            run_op("rnd", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)), $urandom);
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
